// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam int REQ_CPU                = 0;
    localparam int REQ_BLIT               = 1;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Index width that stays at least one bit even for a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first active index at or above i_rr_ptr, wrapping.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_active,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_index
);

    logic [NUM_REQ-1:0][IDX_W-1:0] w_cand;
    logic [NUM_REQ-1:0]            w_hit;

    // w_cand[gi] is the index examined at search distance gi from the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] w_sum;
            assign w_sum       = {1'b0, i_rr_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi]  = (w_sum >= (IDX_W+1)'(NUM_REQ))
                               ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                               : w_sum[IDX_W-1:0];
            assign w_hit[gi]   = i_active[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_valid = 1'b1;
                o_index = w_cand[i];
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory_system port between NUM_REQ byte-wide requesters.
module memory_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [NUM_REQ-1:0]                   req_read,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   req_done,
    output logic                                 req_error,
    output logic [DATA_WIDTH-1:0]                req_rdata,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_write_data,
    output logic                                 mem_dispatch_read,
    output logic                                 mem_dispatch_write,
    input  logic [DATA_WIDTH-1:0]                mem_read_data,
    input  logic                                 mem_finished_op
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t             r_state, state_next;
    logic [IDX_W-1:0]       r_rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]       r_grant, grant_next;
    logic [ADDR_WIDTH-1:0]  r_addr, addr_next;
    logic [DATA_WIDTH-1:0]  r_wdata, wdata_next;
    logic                   r_is_write, is_write_next;
    logic [CNT_W-1:0]       r_cnt, cnt_next;
    logic [DATA_WIDTH-1:0]  r_rdata, rdata_next;
    logic                   r_error, error_next;

    logic [NUM_REQ-1:0]     w_active;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;

    assign w_active = req_read | req_write;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_active (w_active),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_index  (w_pick_idx)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= state_next;
            r_rr_ptr   <= rr_ptr_next;
            r_grant    <= grant_next;
            r_addr     <= addr_next;
            r_wdata    <= wdata_next;
            r_is_write <= is_write_next;
            r_cnt      <= cnt_next;
            r_rdata    <= rdata_next;
            r_error    <= error_next;
        end
    end

    always_comb begin
        state_next    = r_state;
        rr_ptr_next   = r_rr_ptr;
        grant_next    = r_grant;
        addr_next     = r_addr;
        wdata_next    = r_wdata;
        is_write_next = r_is_write;
        cnt_next      = r_cnt;
        rdata_next    = r_rdata;
        error_next    = r_error;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    grant_next    = w_pick_idx;
                    addr_next     = req_addr[w_pick_idx];
                    wdata_next    = req_wdata[w_pick_idx];
                    is_write_next = req_write[w_pick_idx];
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next = '0;
                if (mem_finished_op) begin
                    rdata_next = mem_read_data;
                    error_next = 1'b0;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_finished_op) begin
                    rdata_next = mem_read_data;
                    error_next = 1'b0;
                    state_next = RESP;
                end else begin
                    cnt_next = r_cnt + 1'b1;
                    // Counter reaching TIMEOUT_CYCLES-1 lands RESP exactly TIMEOUT_CYCLES after dispatch.
                    if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                        rdata_next = '0;
                        error_next = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                rr_ptr_next = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr           = r_addr;
    assign mem_write_data     = r_wdata;
    assign mem_dispatch_read  = (r_state == ISSUE) && !r_is_write;
    assign mem_dispatch_write = (r_state == ISSUE) &&  r_is_write;
    assign req_rdata          = r_rdata;
    assign req_error          = r_error;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
            assign req_done[gi] = (r_state == RESP) && (r_grant == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Randomized scoreboard bench for memory_bus_arbiter with a behavioural memory and round-robin model.
`timescale 1ns/1ps
module tb_memory_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic          is_write;
        logic          both;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        int            idx;
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            err;
        int            lat;
    } exp_t;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic [N-1:0]         req_read = '0;
    logic [N-1:0]         req_write = '0;
    logic [N-1:0][AW-1:0] req_addr = '0;
    logic [N-1:0][DW-1:0] req_wdata = '0;
    logic [N-1:0]         req_done;
    logic                 req_error;
    logic [DW-1:0]        req_rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_write_data;
    logic                 mem_dispatch_read;
    logic                 mem_dispatch_write;
    logic [DW-1:0]        mem_read_data = '0;
    logic                 mem_finished_op = 1'b0;

    always #5 clk_in = ~clk_in;

    memory_bus_arbiter #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .req_read           (req_read),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_done           (req_done),
        .req_error          (req_error),
        .req_rdata          (req_rdata),
        .mem_addr           (mem_addr),
        .mem_write_data     (mem_write_data),
        .mem_dispatch_read  (mem_dispatch_read),
        .mem_dispatch_write (mem_dispatch_write),
        .mem_read_data      (mem_read_data),
        .mem_finished_op    (mem_finished_op)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   disp_cnt = 0;
    int   disp_cyc = 0;
    op_t  ops [N][$];
    exp_t sb_q [$];
    int   go_cnt = 0;
    int   stray_cnt = 0;
    int   mem_lat = 1;
    bit   mem_hang = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ---------------- requester + memory_system behavioural model ----------------
    int            go_seen = 0;
    int            stray_seen = 0;
    int            rd [N];
    int            pend = 0;
    bit            pend_write = 1'b0;
    logic [DW-1:0] mem_store [logic [AW-1:0]];

    task automatic load(input int i, input op_t o);
        req_write[i] = o.is_write;
        req_read[i]  = !o.is_write || o.both;
        req_addr[i]  = o.addr;
        req_wdata[i] = o.wdata;
    endtask

    task automatic drop(input int i);
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
        req_addr[i]  = AW'($urandom);
        req_wdata[i] = DW'($urandom);
    endtask

    task automatic finish_op();
        mem_finished_op = 1'b1;
        if (pend_write)
            mem_store[mem_addr] = mem_write_data;
        else
            mem_read_data = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_val(mem_addr);
    endtask

    always @(negedge clk_in) begin
        mem_finished_op = 1'b0;
        mem_read_data   = DW'($urandom);
        if (rst_in) begin
            pend = 0;
            for (int i = 0; i < N; i++) begin
                rd[i] = ops[i].size();
                drop(i);
            end
        end else begin
            if (go_cnt != go_seen) begin
                go_seen = go_cnt;
                for (int i = 0; i < N; i++) begin
                    rd[i] = 0;
                    if (ops[i].size() > 0) begin
                        load(i, ops[i][0]);
                        rd[i] = 1;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_done[i]) begin
                    if (rd[i] < ops[i].size()) begin
                        load(i, ops[i][rd[i]]);
                        rd[i]++;
                    end else begin
                        drop(i);
                    end
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) finish_op();
            end
            if (mem_dispatch_read || mem_dispatch_write) begin
                pend_write = mem_dispatch_write;
                if (!mem_hang) begin
                    if (mem_lat == 0) finish_op();
                    else pend = mem_lat;
                end
            end else if (stray_cnt != stray_seen) begin
                stray_seen      = stray_cnt;
                mem_finished_op = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in) begin
            if (mem_dispatch_read || mem_dispatch_write) begin
                disp_cyc = cyc;
                disp_cnt++;
                check("disp_onehot", 64'(mem_dispatch_read & mem_dispatch_write), 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_dispatch", 64'd1, 64'd0);
                end else begin
                    e = sb_q[0];
                    check("disp_is_write", 64'(mem_dispatch_write), 64'(e.is_write));
                    check("disp_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.is_write) check("disp_wdata", 64'(mem_write_data), 64'(e.wdata));
                end
            end
            if (req_done != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(req_done), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    done_cnt++;
                    check("done_grant", 64'(req_done), 64'd1 << e.idx);
                    check("done_error", 64'(req_error), 64'(e.err));
                    if (!e.is_write || e.err) check("done_rdata", 64'(req_rdata), 64'(e.rdata));
                    check("done_latency", 64'(cyc - disp_cyc), 64'(e.lat));
                    $display("txn %0d: req=%0d %s addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
                             done_cnt, e.idx, e.is_write ? "WR" : "RD", e.addr, e.wdata,
                             req_rdata, req_error, cyc - disp_cyc);
                end
            end
        end
    end

    // ---------------- reference model and stimulus ----------------
    int            m_ptr = 0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic op_t mk(input bit w, input bit both, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.is_write = w;
        o.both     = w & both;
        o.addr     = a;
        o.wdata    = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk(1'($urandom), 1'($urandom), 32'h1000_0000 | 32'($urandom_range(0, 7)), DW'($urandom));
    endfunction

    task automatic clear_ops();
        for (int i = 0; i < N; i++) ops[i].delete();
    endtask

    // Service order: repeatedly the first requester at or after the pointer that still has work.
    task automatic plan_batch(input int lat, input bit hang, output int n_txn);
        int   pos [N];
        int   w;
        int   c;
        op_t  o;
        exp_t e;
        n_txn = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        while (1) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && pos[c] < ops[c].size()) w = c;
            end
            if (w < 0) break;
            o = ops[w][pos[w]];
            pos[w]++;
            e.idx      = w;
            e.is_write = o.is_write;
            e.addr     = o.addr;
            e.wdata    = o.wdata;
            e.err      = hang;
            e.lat      = hang ? TO : lat + 1;
            if (hang) e.rdata = '0;
            else if (o.is_write) begin
                e.rdata = '0;
                ref_mem[o.addr] = o.wdata;
            end else begin
                e.rdata = ref_mem.exists(o.addr) ? ref_mem[o.addr] : init_val(o.addr);
            end
            sb_q.push_back(e);
            n_txn++;
            m_ptr = (w + 1) % N;
        end
        mem_lat  = lat;
        mem_hang = hang;
        go_cnt++;
    endtask

    task automatic run_batch(input int lat, input bit hang);
        int n_txn;
        int budget;
        plan_batch(lat, hang, n_txn);
        budget = n_txn * (TO + 6) + 10;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk_in);
            budget--;
        end
        check("batch_drain", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk_in);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_req_done"}, 64'(req_done), 64'd0);
        check({tag, "_req_error"}, 64'(req_error), 64'd0);
        check({tag, "_req_rdata"}, 64'(req_rdata), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_write_data), 64'd0);
        check({tag, "_disp_rd"}, 64'(mem_dispatch_read), 64'd0);
        check({tag, "_disp_wr"}, 64'(mem_dispatch_write), 64'd0);
    endtask

    initial begin
        int n0;
        int n_txn;
        int budget;

        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check_quiet_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // Directed single read, single write, and read-back of that write.
        clear_ops();
        ops[REQ_CPU].push_back(mk(1'b0, 1'b0, 32'h0000_1234, 8'h00));
        run_batch(2, 1'b0);
        clear_ops();
        ops[REQ_BLIT].push_back(mk(1'b1, 1'b0, 32'hFFFF_FF10, 8'h3C));
        run_batch(3, 1'b0);
        clear_ops();
        ops[2].push_back(mk(1'b0, 1'b0, 32'hFFFF_FF10, 8'h00));
        run_batch(1, 1'b0);

        // Contention: every requester keeps several transactions queued.
        for (int lat = 0; lat < 2; lat++) begin
            clear_ops();
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 3; k++) ops[i].push_back(rand_op());
            run_batch(lat, 1'b0);
        end

        // Random subsets, op mixes and memory latencies.
        for (int b = 0; b < 25; b++) begin
            clear_ops();
            for (int i = 0; i < N; i++) begin
                n0 = $urandom_range(0, 3);
                for (int k = 0; k < n0; k++) ops[i].push_back(rand_op());
            end
            run_batch($urandom_range(0, 3), 1'b0);
        end

        // Timeout, then a normal transaction.
        clear_ops();
        ops[REQ_CPU].push_back(mk(1'b0, 1'b0, 32'h0000_0042, 8'h00));
        run_batch(0, 1'b1);
        clear_ops();
        ops[REQ_CPU].push_back(rand_op());
        run_batch(1, 1'b0);

        // Stray finished_op while idle.
        n0 = done_cnt;
        stray_cnt++;
        repeat (4) @(negedge clk_in);
        check("stray_no_done", 64'(done_cnt), 64'(n0));

        // Reset in the middle of a hung transaction.
        clear_ops();
        ops[REQ_BLIT].push_back(mk(1'b0, 1'b0, 32'h1000_0003, 8'h00));
        n0 = disp_cnt;
        plan_batch(0, 1'b1, n_txn);
        budget = 10;
        while (disp_cnt == n0 && budget > 0) begin
            @(negedge clk_in);
            budget--;
        end
        check("rst_dispatch_seen", 64'(disp_cnt - n0), 64'd1);
        repeat (3) @(negedge clk_in);
        n0 = done_cnt;
        rst_in = 1'b1;
        @(negedge clk_in);
        check_quiet_outputs("midrst");
        @(negedge clk_in);
        rst_in = 1'b0;
        sb_q.delete();
        m_ptr = 0;
        repeat (2) @(negedge clk_in);
        check("rst_no_done", 64'(done_cnt), 64'(n0));

        clear_ops();
        for (int i = 0; i < N; i++) ops[i].push_back(rand_op());
        run_batch(1, 1'b0);
        clear_ops();
        ops[REQ_BLIT].push_back(rand_op());
        run_batch(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
